instr_check_sequencer: RTL
==========================

INSTR_CHECK_SEQUENCER -- requirements
Module: instr_check_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8: vector table entries (power of 2, >=2); AW = clog2(DEPTH).
REQ-002 SHALL have parameter DATA_W, default 32: width of expected value and result_in.
REQ-003 SHALL have parameter SETTLE, default 1: wait cycles between step and check (0..15).
REQ-004 SHALL have parameter STOP_ON_FAIL, default 0: 1 ends the run at the first mismatch.
REQ-005 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port load_en  input  1  write one table entry this cycle.
REQ-008 SHALL have port load_addr  input  AW  table index to write.
REQ-009 SHALL have port load_instr  input  32  instruction word to store.
REQ-010 SHALL have port load_expect  input  DATA_W  expected result to store.
REQ-011 SHALL have port load_check  input  1  1 = compare result for this entry.
REQ-012 SHALL have port start  input  1  begin a run (single-cycle pulse).
REQ-013 SHALL have port num_vec  input  AW+1  vectors to run, sampled with start.
REQ-014 SHALL have port result_in  input  DATA_W  CPU result bus (e.g. ALUResult).
REQ-015 SHALL have port instr_out  output  32  instruction driven to the CPU.
REQ-016 SHALL have port step  output  1  one-cycle CPU advance strobe.
REQ-017 SHALL have ports busy, done, all_pass  output  1 each  run status.
REQ-018 SHALL have ports fail_cnt  output  AW+1, first_fail_idx  output  AW, first_fail_valid  output  1.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, SETTLE, CHECK, DONE.
REQ-020 load_en SHALL write {load_instr, load_expect, load_check} at load_addr only in IDLE or DONE; ignored otherwise.
REQ-021 start in IDLE/DONE SHALL clear fail_cnt, first_fail_*, done, idx, latch min(num_vec, DEPTH) as N, and enter ISSUE; start while busy SHALL be ignored.
REQ-022 start with num_vec=0 SHALL go directly to DONE with fail_cnt=0 and all_pass=1 one cycle later.
REQ-023 On entering ISSUE, instr_out SHALL register table[idx] and hold it until the next ISSUE; step SHALL be 1 only during ISSUE.
REQ-024 ISSUE SHALL last 1 cycle, then SETTLE for exactly SETTLE cycles (skipped when 0), then CHECK for 1 cycle; per-vector time = 2+SETTLE cycles.
REQ-025 In CHECK, if the check bit is set and result_in != expect, fail_cnt SHALL increment (saturating at all-ones) and, if first_fail_valid=0, first_fail_idx<=idx and first_fail_valid<=1.
REQ-026 After CHECK, next state SHALL be DONE when idx==N-1 or (STOP_ON_FAIL=1 and mismatch), else ISSUE with idx+1.
REQ-027 Entries with check bit 0 SHALL never count as failures.
REQ-028 busy SHALL be 1 in ISSUE/SETTLE/CHECK; done SHALL be 1 in DONE and hold until the next start or reset.
REQ-029 all_pass SHALL equal done AND (fail_cnt==0).
REQ-030 A run started at edge k SHALL assert done from edge k+1+N*(2+SETTLE).

Reset
REQ-031 rst=0 SHALL immediately force IDLE, instr_out=32'hE1A00000 (NOP), step=0, busy=0, done=0, all_pass=0, fail_cnt=0, first_fail_idx=0, first_fail_valid=0, including mid-run.
REQ-032 Table contents SHALL be unaffected by reset (no reset on storage).

Verification
REQ-033 Reset mid-run (SETTLE state, idx=1) -> outputs at reset values same cycle; idle after release; new start runs from idx 0.
REQ-034 DEPTH=8, SETTLE=1: load {E3A01003,3,1},{E2811000,3,1}, num_vec=2, result_in=3 -> done at k+7, all_pass=1, fail_cnt=0, two step pulses with instr_out E3A01003 then E2811000.
REQ-035 Entry 1 expect 32'hFFFFFFFF, result_in=1 during its CHECK -> fail_cnt=1, first_fail_idx=1, first_fail_valid=1, all_pass=0.
REQ-036 STOP_ON_FAIL=1, num_vec=4, mismatch at idx 0 -> done at k+4, fail_cnt=1, exactly one step pulse.
REQ-037 num_vec=0 -> done at k+1, all_pass=1, no step; num_vec=12 (DEPTH=8) -> exactly 8 step pulses.
REQ-038 start and load_en asserted while busy -> no restart, table entry unchanged, run completes as originally scheduled.

Source files
------------

// File: rtl/instr_check_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_check_sequencer
// Description : Steps a CPU through a table of instruction vectors. Each
//               vector is issued with a one-cycle step strobe, given SETTLE
//               cycles to propagate, then the CPU result is compared against
//               the stored expectation. Reports pass/fail totals and the index
//               of the first failing vector.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_check_sequencer #(
  parameter int DEPTH        = 8,
  parameter int DATA_W       = 32,
  parameter int SETTLE       = 1,
  parameter int STOP_ON_FAIL = 0,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [AW-1:0]     load_addr,
  input  logic [31:0]       load_instr,
  input  logic [DATA_W-1:0] load_expect,
  input  logic              load_check,
  input  logic              start,
  input  logic [AW:0]       num_vec,
  input  logic [DATA_W-1:0] result_in,
  output logic [31:0]       instr_out,
  output logic              step,
  output logic              busy,
  output logic              done,
  output logic              all_pass,
  output logic [AW:0]       fail_cnt,
  output logic [AW-1:0]     first_fail_idx,
  output logic              first_fail_valid
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [31:0] c_nop         = 32'hE1A00000;
  localparam int          c_settle_last = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [AW:0] c_depth       = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_fail_max    = '1;

  // Vector storage; deliberately not reset so a table survives a reset.
  logic [31:0]       tbl_instr_q  [DEPTH];
  logic [DATA_W-1:0] tbl_expect_q [DEPTH];
  logic              tbl_check_q  [DEPTH];

  state_t            state_q, state_d;
  logic              launch_q, launch_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [AW:0]       n_q, n_d;
  logic [3:0]        settle_q, settle_d;
  logic [AW:0]       fail_cnt_q, fail_cnt_d;
  logic [AW-1:0]     ffi_q, ffi_d;
  logic              ffv_q, ffv_d;
  logic [31:0]       instr_q, instr_d;

  logic              accepting;
  logic              mismatch;
  logic              last_vec;

  assign accepting = (state_q == S_IDLE) || (state_q == S_DONE);
  assign mismatch  = (state_q == S_CHECK) && tbl_check_q[idx_q] &&
                     (result_in != tbl_expect_q[idx_q]);
  assign last_vec  = ({1'b0, idx_q} == (n_q - (AW+1)'(1)));

  // Table write port, only open while no run is in flight.
  always_ff @(posedge clk) begin
    if (load_en && accepting) begin
      tbl_instr_q[load_addr]  <= load_instr;
      tbl_expect_q[load_addr] <= load_expect;
      tbl_check_q[load_addr]  <= load_check;
    end
  end

  // Next-state and datapath updates. A start is taken in a one-cycle launch
  // phase (IDLE with launch_q set) before the first vector is issued.
  always_comb begin
    state_d    = state_q;
    launch_d   = 1'b0;
    idx_d      = idx_q;
    n_d        = n_q;
    settle_d   = settle_q;
    fail_cnt_d = fail_cnt_q;
    ffi_d      = ffi_q;
    ffv_d      = ffv_q;
    instr_d    = instr_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (launch_q) begin
          state_d = (n_q == '0) ? S_DONE : S_ISSUE;
        end else if (start) begin
          state_d    = S_IDLE;
          launch_d   = 1'b1;
          idx_d      = '0;
          n_d        = (num_vec > c_depth) ? c_depth : num_vec;
          fail_cnt_d = '0;
          ffi_d      = '0;
          ffv_d      = 1'b0;
        end
      end
      S_ISSUE: begin
        if (SETTLE == 0) begin
          state_d = S_CHECK;
        end else begin
          state_d  = S_SETTLE;
          settle_d = 4'(c_settle_last);
        end
      end
      S_SETTLE: begin
        if (settle_q == 4'd0) begin
          state_d = S_CHECK;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          if (fail_cnt_q != c_fail_max) begin
            fail_cnt_d = fail_cnt_q + (AW+1)'(1);
          end
          if (!ffv_q) begin
            ffi_d = idx_q;
            ffv_d = 1'b1;
          end
        end
        if (last_vec || ((STOP_ON_FAIL != 0) && mismatch)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
          idx_d   = idx_q + (AW)'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The instruction register captures the vector as ISSUE is entered.
    if (state_d == S_ISSUE) begin
      instr_d = tbl_instr_q[idx_d];
    end
  end

  // Control and status registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      launch_q   <= 1'b0;
      idx_q      <= '0;
      n_q        <= '0;
      settle_q   <= 4'd0;
      fail_cnt_q <= '0;
      ffi_q      <= '0;
      ffv_q      <= 1'b0;
      instr_q    <= c_nop;
    end else begin
      state_q    <= state_d;
      launch_q   <= launch_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      settle_q   <= settle_d;
      fail_cnt_q <= fail_cnt_d;
      ffi_q      <= ffi_d;
      ffv_q      <= ffv_d;
      instr_q    <= instr_d;
    end
  end

  assign instr_out        = instr_q;
  assign step             = (state_q == S_ISSUE);
  assign busy             = (state_q == S_ISSUE) || (state_q == S_SETTLE) ||
                            (state_q == S_CHECK);
  assign done             = (state_q == S_DONE);
  assign all_pass         = done && (fail_cnt_q == '0);
  assign fail_cnt         = fail_cnt_q;
  assign first_fail_idx   = ffi_q;
  assign first_fail_valid = ffv_q;

endmodule
`default_nettype wire
